// File: rtl/dmem_sram_bridge_pkg.sv
// Shared definitions for the data-memory to SRAM-bus bridge: FSM states,
// bus transfer sizes and the kseg0/kseg1 virtual-to-physical mapping.
package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

  // kseg0 and kseg1 (0x8000_0000-0xBFFF_FFFF) alias the low 512 MB of physical space.
  function automatic logic [31:0] map_addr(input logic [31:0] vaddr, input logic map_en);
    logic [31:0] paddr;
    paddr = vaddr;
    if (map_en && (vaddr[31:30] == 2'b10)) begin
      paddr = vaddr & KSEG_PHYS_MASK;
    end
    return paddr;
  endfunction

endpackage

// File: rtl/dmem_sram_bridge_wen_to_size.sv
// Decodes the core's byte write enables into bus direction and transfer size.
// Patterns that are not a byte, an aligned half or a full word are flagged illegal.
module dmem_sram_bridge_wen_to_size
  import dmem_sram_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic       wr,
  output logic [1:0] size,
  output logic       illegal
);

  always_comb begin
    wr      = 1'b1;
    size    = SIZE_BYTE;
    illegal = 1'b0;
    unique case (wen)
      4'b0000: begin
        wr   = 1'b0;
        size = SIZE_WORD;
      end
      4'b1111:                            size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Bridges the core's single-cycle data-memory port onto a split-transaction
// SRAM-like bus, stalling the core until the response arrives.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter bit ADDR_MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_en,
  input  logic [3:0]  cpu_mem_wen,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_advance,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_e      state_q, state_d;
  logic        data_req_q, data_req_d;
  logic        data_wr_q, data_wr_d;
  logic [1:0]  data_size_q, data_size_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_illegal;
  logic [31:0] req_paddr;

  dmem_sram_bridge_wen_to_size u_wen_to_size (
    .wen     (cpu_mem_wen),
    .wr      (req_wr),
    .size    (req_size),
    .illegal (req_illegal)
  );

  // Reads always fetch the whole aligned word; the core picks the lanes it needs.
  always_comb begin
    req_paddr = map_addr(cpu_mem_addr, ADDR_MAP_EN);
    if (!req_wr) begin
      req_paddr[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= SIZE_BYTE;
      data_addr_q  <= 32'h0;
      data_wdata_q <= 32'h0;
      cpu_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_size_d  = data_size_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_stall    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Bus responses seen here are stale (e.g. left over from a reset mid-access).
        if (cpu_mem_en) begin
          cpu_stall    = 1'b1;
          state_d      = ST_REQ;
          data_req_d   = 1'b1;
          data_wr_d    = req_wr;
          data_size_d  = req_size;
          data_addr_d  = req_paddr;
          data_wdata_d = cpu_wdata;
        end
      end
      ST_REQ: begin
        cpu_stall = 1'b1;
        if (data_addr_ok) begin
          data_req_d = 1'b0;
          if (data_data_ok) begin
            state_d = ST_DONE;
            if (!data_wr_q) begin
              cpu_rdata_d = data_rdata;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cpu_stall = 1'b1;
        if (data_data_ok) begin
          state_d = ST_DONE;
          if (!data_wr_q) begin
            cpu_rdata_d = data_rdata;
          end
        end
      end
      ST_DONE: begin
        // cpu_mem_en is still high for the finished instruction; only advance releases us.
        if (cpu_advance) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;

  a_legal_wen: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_IDLE && cpu_mem_en) |-> !req_illegal);

  a_no_early_data_ok: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_REQ && !data_addr_ok) |-> !data_data_ok);

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: mapped and unmapped instances, scripted bus responses.
module tb_dmem_sram_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_mem_en, cpu_advance, cpu_stall;
  logic [3:0]  cpu_mem_wen;
  logic [31:0] cpu_mem_addr, cpu_wdata, cpu_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  logic        cpu_mem_en_b, cpu_advance_b, cpu_stall_b;
  logic [3:0]  cpu_mem_wen_b;
  logic [31:0] cpu_mem_addr_b, cpu_wdata_b, cpu_rdata_b;
  logic        data_req_b, data_wr_b, data_addr_ok_b, data_data_ok_b;
  logic [1:0]  data_size_b;
  logic [31:0] data_addr_b, data_wdata_b, data_rdata_b;

  dmem_sram_bridge #(.ADDR_MAP_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_mem_en(cpu_mem_en), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_addr(cpu_mem_addr),
    .cpu_wdata(cpu_wdata), .cpu_advance(cpu_advance), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  dmem_sram_bridge #(.ADDR_MAP_EN(1'b0)) u_dut_nomap (
    .clk(clk), .rst(rst),
    .cpu_mem_en(cpu_mem_en_b), .cpu_mem_wen(cpu_mem_wen_b), .cpu_mem_addr(cpu_mem_addr_b),
    .cpu_wdata(cpu_wdata_b), .cpu_advance(cpu_advance_b), .cpu_rdata(cpu_rdata_b),
    .cpu_stall(cpu_stall_b), .data_req(data_req_b), .data_wr(data_wr_b), .data_size(data_size_b),
    .data_addr(data_addr_b), .data_wdata(data_wdata_b), .data_addr_ok(data_addr_ok_b),
    .data_data_ok(data_data_ok_b), .data_rdata(data_rdata_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the mapped instance with a scripted bus: addr_ok after aok_dly
  // cycles of data_req, data_ok dok_dly cycles after addr_ok (0 = same cycle).
  task automatic access(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int aok_dly, input int dok_dly,
                        input logic [31:0] rd, input logic [31:0] exp_addr,
                        input logic [1:0] exp_size, input logic exp_wr, input int exp_stall);
    int cyc, req_cyc, wait_cyc, stall_cycles, issues;
    bit prev_req, done, unstable, seen;
    logic [31:0] first_addr;
    cyc = 0; req_cyc = 0; wait_cyc = -1; stall_cycles = 0; issues = 0;
    prev_req = 1'b0; done = 1'b0; unstable = 1'b0; seen = 1'b0; first_addr = 32'hFFFF_FFFF;
    cpu_mem_en = 1'b1; cpu_mem_wen = wen; cpu_mem_addr = addr; cpu_wdata = wdata;
    cpu_advance = 1'b0;
    while (!done && cyc < 40) begin
      #2;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (data_req) begin
        if (!prev_req) issues++;
        if (!seen) begin
          first_addr = data_addr;
          seen = 1'b1;
        end
        if (data_addr !== exp_addr || data_size !== exp_size || data_wr !== exp_wr ||
            (exp_wr && data_wdata !== wdata)) unstable = 1'b1;
        if (req_cyc == aok_dly) begin
          data_addr_ok = 1'b1;
          if (dok_dly == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = rd;
          end else begin
            wait_cyc = dok_dly;
          end
        end
        req_cyc++;
      end else if (wait_cyc > 0) begin
        wait_cyc--;
        if (wait_cyc == 0) begin
          data_data_ok = 1'b1;
          data_rdata   = rd;
          wait_cyc     = -1;
        end
      end
      prev_req = data_req;
      #1;
      if (cpu_stall) stall_cycles++;
      else done = 1'b1;
      step();
      cyc++;
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    chk({tag, "_completed"}, {31'h0, done}, 32'h1);
    chk({tag, "_stall_cycles"}, stall_cycles, exp_stall);
    chk({tag, "_issues"}, issues, 32'd1);
    chk({tag, "_addr"}, first_addr, exp_addr);
    chk({tag, "_fields_stable"}, {31'h0, unstable}, 32'h0);
    #2;
    chk({tag, "_done_no_req"}, {31'h0, data_req}, 32'h0);
  endtask

  task automatic retire(input logic next_en);
    cpu_advance = 1'b1;
    step();
    cpu_advance = 1'b0;
    cpu_mem_en  = next_en;
  endtask

  initial begin
    rst = 1'b1;
    cpu_mem_en = 1'b0; cpu_mem_wen = 4'h0; cpu_mem_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_advance = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    cpu_mem_en_b = 1'b0; cpu_mem_wen_b = 4'h0; cpu_mem_addr_b = 32'h0; cpu_wdata_b = 32'h0;
    cpu_advance_b = 1'b0; data_addr_ok_b = 1'b0; data_data_ok_b = 1'b0; data_rdata_b = 32'h0;
    step(); step();
    rst = 1'b0;
    #2;
    chk("rst_req",   {31'h0, data_req}, 32'h0);
    chk("rst_wr",    {31'h0, data_wr}, 32'h0);
    chk("rst_size",  {30'h0, data_size}, 32'h0);
    chk("rst_addr",  data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    step();

    // 1: kseg1 word read, addr_ok one cycle late, data_ok one cycle after that
    access("t1", 4'b0000, 32'hBFC0_0010, 32'h0, 1, 1, 32'hDEAD_BEEF,
           32'h1FC0_0010, 2'd2, 1'b0, 4);
    chk("t1_size",  {30'h0, data_size}, 32'd2);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_stall_done", {31'h0, cpu_stall}, 32'h0);
    retire(1'b0);

    // 2: byte write, zero-latency bus; read data on the bus must not be captured
    access("t2", 4'b0100, 32'h8000_0003, 32'h00AB_0000, 0, 0, 32'h1234_5678,
           32'h0000_0003, 2'd0, 1'b1, 2);
    chk("t2_wr",    {31'h0, data_wr}, 32'h1);
    chk("t2_wdata", data_wdata, 32'h00AB_0000);
    chk("t2_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);

    // 3: hold in DONE with cpu_mem_en still high
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      chk("t3_hold_stall", {31'h0, cpu_stall}, 32'h0);
      chk("t3_hold_req",   {31'h0, data_req}, 32'h0);
    end
    retire(1'b0);
    #2;
    chk("t3_idle_stall", {31'h0, cpu_stall}, 32'h0);
    step();
    #2;
    chk("t3_idle_req", {31'h0, data_req}, 32'h0);
    step();

    // 4: reset while waiting for data_ok, then a late data_ok
    cpu_mem_en = 1'b1; cpu_mem_wen = 4'b0000; cpu_mem_addr = 32'h8000_1000;
    step();
    #2;
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #2;
    chk("t4_wait_stall", {31'h0, cpu_stall}, 32'h1);
    chk("t4_wait_req",   {31'h0, data_req}, 32'h0);
    #1;
    rst = 1'b1;
    cpu_mem_en = 1'b0;
    #1;
    chk("t4_rst_rdata", cpu_rdata, 32'h0);
    chk("t4_rst_addr",  data_addr, 32'h0);
    chk("t4_rst_size",  {30'h0, data_size}, 32'h0);
    chk("t4_rst_stall", {31'h0, cpu_stall}, 32'h0);
    step();
    rst = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    step();
    data_data_ok = 1'b0;
    #2;
    chk("t4_late_rdata", cpu_rdata, 32'h0);
    chk("t4_late_stall", {31'h0, cpu_stall}, 32'h0);
    chk("t4_late_req",   {31'h0, data_req}, 32'h0);
    step();

    // 5: unmapped instance, half-word address read
    cpu_mem_en_b = 1'b1; cpu_mem_wen_b = 4'b0000; cpu_mem_addr_b = 32'h8000_0006;
    #2;
    chk("t5_idle_stall", {31'h0, cpu_stall_b}, 32'h1);
    step();
    #2;
    chk("t5_req",  {31'h0, data_req_b}, 32'h1);
    chk("t5_addr", data_addr_b, 32'h8000_0004);
    chk("t5_size", {30'h0, data_size_b}, 32'd2);
    chk("t5_wr",   {31'h0, data_wr_b}, 32'h0);
    data_addr_ok_b = 1'b1; data_data_ok_b = 1'b1; data_rdata_b = 32'h1122_3344;
    step();
    data_addr_ok_b = 1'b0; data_data_ok_b = 1'b0;
    #2;
    chk("t5_done_stall", {31'h0, cpu_stall_b}, 32'h0);
    chk("t5_rdata", cpu_rdata_b, 32'h1122_3344);
    cpu_advance_b = 1'b1;
    step();
    cpu_advance_b = 1'b0; cpu_mem_en_b = 1'b0;

    // 6: back-to-back reads, addr_ok held off for 5 cycles
    access("t6a", 4'b0000, 32'h0000_0102, 32'h0, 5, 1, 32'hA5A5_0001,
           32'h0000_0100, 2'd2, 1'b0, 8);
    chk("t6a_rdata", cpu_rdata, 32'hA5A5_0001);
    retire(1'b1);
    access("t6b", 4'b0000, 32'h0000_0104, 32'h0, 5, 0, 32'hA5A5_0002,
           32'h0000_0104, 2'd2, 1'b0, 7);
    chk("t6b_rdata", cpu_rdata, 32'hA5A5_0002);
    retire(1'b0);
    step();
    #2;
    chk("t6_idle_req", {31'h0, data_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
